// File: rtl/mac_beams_grp_pkg.sv
// Shared definitions for the beam-forming MAC: derived sizes, packet FSM
// states, error-flag bit positions and the I/Q sample struct.
package mac_beams_grp_pkg;

    // Antennas per group
    function automatic int f_apg(input int ant, input int ngrp);
        return ant / ngrp;
    endfunction

    // Accumulator width: full complex product, plus one bit for the I/Q
    // add/subtract, plus growth for summing every antenna
    function automatic int f_aw(input int iw, input int cw, input int ant);
        return iw / 2 + cw / 2 + 1 + $clog2(ant);
    endfunction

    // Input reg + 2-stage complex multiply + adder tree + group-sum/round/sat
    function automatic int f_lat(input int ant, input int ngrp);
        return 4 + $clog2(ant / ngrp);
    endfunction

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } state_e;

    localparam int ERR_SOP = 0;  // sop seen inside a packet
    localparam int ERR_EOP = 1;  // eop seen outside a packet
    localparam int ERR_SAT = 2;  // output saturation

    // Default 32-bit sample packing: Q in the upper half, I in the lower half
    typedef struct packed {
        logic signed [15:0] q;
        logic signed [15:0] i;
    } cplx_t;

endpackage

// File: rtl/mac_beams_grp_cmac_tree.sv
// One beam x one antenna group: complex multiply (2 stages) followed by a
// fully registered binary adder tree. Fixed latency 2 + $clog2(APG).
// Leaf count is padded to a power of two with constant-zero leaves.
module beam_cmac_tree #(
    parameter int APG = 16,
    parameter int IW  = 32,
    parameter int CW  = 32,
    parameter int AW  = 38
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [APG*IW-1:0]    x_i,
    input  logic [APG*CW-1:0]    w_i,
    output logic signed [AW-1:0] re_o,
    output logic signed [AW-1:0] im_o
);
    localparam int HI = IW / 2;
    localparam int HW = CW / 2;
    localparam int PW = HI + HW;
    localparam int L  = $clog2(APG);
    localparam int NP = 1 << L;
    localparam int NN = 2 * NP - 1;

    logic signed [PW-1:0] rr_q [APG];
    logic signed [PW-1:0] ii_q [APG];
    logic signed [PW-1:0] ri_q [APG];
    logic signed [PW-1:0] ir_q [APG];
    // Heap-ordered tree: node n sums nodes 2n+1 and 2n+2, leaves at NP-1..NN-1
    logic signed [AW-1:0] nre_q [NN];
    logic signed [AW-1:0] nim_q [NN];

    // Stage 1: the four partial products of every antenna
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int a = 0; a < APG; a++) begin
                rr_q[a] <= '0;
                ii_q[a] <= '0;
                ri_q[a] <= '0;
                ir_q[a] <= '0;
            end
        end else begin
            for (int a = 0; a < APG; a++) begin
                rr_q[a] <= PW'($signed(x_i[a*IW +: HI])) * PW'($signed(w_i[a*CW +: HW]));
                ii_q[a] <= PW'($signed(x_i[a*IW+HI +: HI])) * PW'($signed(w_i[a*CW+HW +: HW]));
                ri_q[a] <= PW'($signed(x_i[a*IW +: HI])) * PW'($signed(w_i[a*CW+HW +: HW]));
                ir_q[a] <= PW'($signed(x_i[a*IW+HI +: HI])) * PW'($signed(w_i[a*CW +: HW]));
            end
        end
    end

    // Stage 2 (leaves) and the registered adder-tree levels
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int n = 0; n < NN; n++) begin
                nre_q[n] <= '0;
                nim_q[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NP - 1; n++) begin
                nre_q[n] <= nre_q[2*n+1] + nre_q[2*n+2];
                nim_q[n] <= nim_q[2*n+1] + nim_q[2*n+2];
            end
            for (int a = 0; a < APG; a++) begin
                nre_q[NP-1+a] <= AW'(rr_q[a]) - AW'(ii_q[a]);
                nim_q[NP-1+a] <= AW'(ri_q[a]) + AW'(ir_q[a]);
            end
            for (int a = APG; a < NP; a++) begin
                nre_q[NP-1+a] <= '0;
                nim_q[NP-1+a] <= '0;
            end
        end
    end

    assign re_o = nre_q[0];
    assign im_o = nim_q[0];

endmodule

// File: rtl/mac_beams_grp.sv
// Beam-forming MAC top: double-buffered codebook, packet FSM with sticky
// error flags, BEAM x NGRP complex MAC trees, group sum, round half-up and
// saturation, plus the control delay line that aligns valid/sop/eop.
// Optional build macro MAC_BEAMS_GRP_DBG_EN adds o_grp_i/o_grp_q with the
// rounded/saturated per-group sums.
module mac_beams_grp
    import mac_beams_grp_pkg::*;
#(
    parameter int BEAM  = 16,
    parameter int ANT   = 32,
    parameter int NGRP  = 2,
    parameter int IW    = 32,
    parameter int CW    = 32,
    parameter int OW    = 24,
    parameter int SHIFT = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [ANT*IW-1:0]         i_ants_data,
    input  logic                      i_rvalid,
    input  logic                      i_sop,
    input  logic                      i_eop,
    input  logic                      i_cw_wr,
    input  logic [$clog2(BEAM)-1:0]   i_cw_beam,
    input  logic [ANT*CW-1:0]         i_cw_data,
    input  logic                      i_cw_commit,
    input  logic                      i_err_clr,
    output logic [BEAM*OW-1:0]        o_data_i,
    output logic [BEAM*OW-1:0]        o_data_q,
    output logic                      o_tvalid,
    output logic                      o_sop,
    output logic                      o_eop,
    output logic                      o_cw_pend,
    output logic [2:0]                o_err
`ifdef MAC_BEAMS_GRP_DBG_EN
    ,
    output logic [BEAM*NGRP*OW-1:0]   o_grp_i,
    output logic [BEAM*NGRP*OW-1:0]   o_grp_q
`endif
);
    localparam int APG = f_apg(ANT, NGRP);
    localparam int AW  = f_aw(IW, CW, ANT);
    localparam int LAT = f_lat(ANT, NGRP);
    localparam int BW  = $clog2(BEAM);
    localparam int SH1 = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [AW:0] ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic signed [AW:0] RND  = (SHIFT > 0) ? (ONE <<< SH1) : {(AW+1){1'b0}};
    localparam logic signed [AW:0] MAXV = {{(AW+2-OW){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW:0] MINV = ~MAXV;

    // Round half-up then arithmetic shift; one extra bit absorbs the rounding carry
    function automatic logic signed [AW:0] rnd_shift(input logic signed [AW-1:0] a);
        return ((AW+1)'(a) + RND) >>> SHIFT;
    endfunction

    function automatic logic [OW-1:0] sat_val(input logic signed [AW:0] t);
        if (t > MAXV) begin
            return MAXV[OW-1:0];
        end else if (t < MINV) begin
            return MINV[OW-1:0];
        end else begin
            return t[OW-1:0];
        end
    endfunction

    function automatic logic is_sat(input logic signed [AW:0] t);
        return (t > MAXV) || (t < MINV);
    endfunction

    logic [ANT*CW-1:0]    bank_q [2][BEAM];
    logic                 act_q;
    logic                 act_d;
    logic                 pend_q;
    logic                 swap_s;
    state_e               state_q;
    logic [ANT*IW-1:0]    x_q;
    logic [LAT-2:0]       v_q;
    logic [LAT-2:0]       s_q;
    logic [LAT-2:0]       e_q;
    logic signed [AW-1:0] gre_s [BEAM][NGRP];
    logic signed [AW-1:0] gim_s [BEAM][NGRP];
    logic [OW-1:0]        ri_s [BEAM];
    logic [OW-1:0]        rq_s [BEAM];
    logic                 sat_s;
    logic [2:0]           err_set_s;

    // A pending (or simultaneous) commit swaps banks on a valid sop beat, so
    // the active bank only ever changes at a packet boundary
    always_comb begin
        swap_s = i_rvalid & i_sop & (pend_q | i_cw_commit);
        act_d  = act_q ^ swap_s;
    end

    // Codebook banks, active-bank pointer and commit-pending flag;
    // writes always land in the bank that is shadow after this edge
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < 2; k++) begin
                for (int b = 0; b < BEAM; b++) begin
                    bank_q[k][b] <= '0;
                end
            end
            act_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            act_q <= act_d;
            if (swap_s) begin
                pend_q <= 1'b0;
            end else if (i_cw_commit) begin
                pend_q <= 1'b1;
            end
            for (int b = 0; b < BEAM; b++) begin
                if (i_cw_wr && (i_cw_beam == BW'(b))) begin
                    bank_q[~act_d][b] <= i_cw_data;
                end
            end
        end
    end

    assign o_cw_pend = pend_q;

    // Input register and valid/sop/eop delay line matching the MAC pipeline
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            x_q <= '0;
            v_q <= '0;
            s_q <= '0;
            e_q <= '0;
        end else begin
            v_q <= {v_q[LAT-3:0], i_rvalid};
            s_q <= {s_q[LAT-3:0], i_rvalid & i_sop};
            e_q <= {e_q[LAT-3:0], i_rvalid & i_eop};
            if (i_rvalid) begin
                x_q <= i_ants_data;
            end
        end
    end

    for (genvar b = 0; b < BEAM; b++) begin : g_beam
        for (genvar g = 0; g < NGRP; g++) begin : g_grp
            beam_cmac_tree #(
                .APG (APG),
                .IW  (IW),
                .CW  (CW),
                .AW  (AW)
            ) u_tree (
                .clk_i (i_clk),
                .rst_i (i_rst),
                .x_i   (x_q[g*APG*IW +: APG*IW]),
                .w_i   (bank_q[act_q][b][g*APG*CW +: APG*CW]),
                .re_o  (gre_s[b][g]),
                .im_o  (gim_s[b][g])
            );
        end
    end

    // Group sum, rounding and saturation for every beam
    always_comb begin
        sat_s = 1'b0;
        for (int b = 0; b < BEAM; b++) begin
            logic signed [AW-1:0] acc_i;
            logic signed [AW-1:0] acc_q;
            acc_i = '0;
            acc_q = '0;
            for (int g = 0; g < NGRP; g++) begin
                acc_i = acc_i + gre_s[b][g];
                acc_q = acc_q + gim_s[b][g];
            end
            ri_s[b] = sat_val(rnd_shift(acc_i));
            rq_s[b] = sat_val(rnd_shift(acc_q));
            sat_s   = sat_s | is_sat(rnd_shift(acc_i)) | is_sat(rnd_shift(acc_q));
        end
    end

    // Output stage: data updates only on valid cycles and holds otherwise
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_tvalid <= 1'b0;
            o_sop    <= 1'b0;
            o_eop    <= 1'b0;
            o_data_i <= '0;
            o_data_q <= '0;
        end else begin
            o_tvalid <= v_q[LAT-2];
            o_sop    <= s_q[LAT-2];
            o_eop    <= e_q[LAT-2];
            if (v_q[LAT-2]) begin
                for (int b = 0; b < BEAM; b++) begin
                    o_data_i[b*OW +: OW] <= ri_s[b];
                    o_data_q[b*OW +: OW] <= rq_s[b];
                end
            end
        end
    end

    // Error conditions detected this cycle
    always_comb begin
        err_set_s          = 3'b000;
        err_set_s[ERR_SOP] = i_rvalid & i_sop & (state_q == ST_IN_PKT);
        err_set_s[ERR_EOP] = i_rvalid & i_eop & ~i_sop & (state_q == ST_IDLE);
        err_set_s[ERR_SAT] = v_q[LAT-2] & sat_s;
    end

    // Packet FSM (valid beats only) and sticky error flags; a new set beats clear
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            o_err   <= 3'b000;
        end else begin
            o_err <= (o_err & ~{3{i_err_clr}}) | err_set_s;
            if (i_rvalid) begin
                case (state_q)
                    ST_IDLE: begin
                        if (i_sop && !i_eop) begin
                            state_q <= ST_IN_PKT;
                        end
                    end
                    ST_IN_PKT: begin
                        if (i_eop) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef MAC_BEAMS_GRP_DBG_EN
    logic [OW-1:0] gri_s [BEAM*NGRP];
    logic [OW-1:0] grq_s [BEAM*NGRP];

    // Per-group rounding/saturation; never contributes to the error flags
    always_comb begin
        for (int b = 0; b < BEAM; b++) begin
            for (int g = 0; g < NGRP; g++) begin
                gri_s[b*NGRP+g] = sat_val(rnd_shift(gre_s[b][g]));
                grq_s[b*NGRP+g] = sat_val(rnd_shift(gim_s[b][g]));
            end
        end
    end

    // Debug group outputs, aligned with o_tvalid and held between valid beats
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_grp_i <= '0;
            o_grp_q <= '0;
        end else begin
            if (v_q[LAT-2]) begin
                for (int k = 0; k < BEAM*NGRP; k++) begin
                    o_grp_i[k*OW +: OW] <= gri_s[k];
                    o_grp_q[k*OW +: OW] <= grq_s[k];
                end
            end
        end
    end
`endif

endmodule
